// File: rtl/axi_lite_regs.sv
// AXI4-Lite slave register file: NUM_RW read/write control registers that
// drive PL logic, followed by read-only status registers that PL logic drives.
// The write and read channels run independent FSMs, one transaction each.
module axi_lite_regs #(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_REGS   = 8,
  parameter int NUM_RW     = 4
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [31:0]                    s_axi_wdata,
  input  logic [3:0]                     s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [31:0]                    s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_RW*32-1:0]           ctrl_o,
  output logic [NUM_RW-1:0]              wr_pulse_o,
  input  logic [(NUM_REGS-NUM_RW)*32-1:0] status_i
);

  localparam int          IDX_W       = ADDR_WIDTH - 2;
  localparam int          NUM_RO      = NUM_REGS - NUM_RW;
  localparam logic [31:0] NUM_RW_U    = 32'(NUM_RW);
  localparam logic [31:0] NUM_REGS_U  = 32'(NUM_REGS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  logic              init_q;
  logic [31:0]       ctrl_q [NUM_RW];
  w_state_t          w_state_q, w_state_d;
  r_state_t          r_state_q, r_state_d;
  logic [IDX_W-1:0]  aw_idx_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic [1:0]        bresp_q;
  logic [NUM_RW-1:0] wr_pulse_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;

  logic              aw_hs, w_hs, ar_hs;
  logic              lat_aw, lat_w, commit;
  logic [IDX_W-1:0]  commit_idx;
  logic [31:0]       commit_data;
  logic [3:0]        commit_strb;
  logic [31:0]       commit_idx32, rd_idx32;
  logic              commit_rw;
  logic [31:0]       rd_mux;

  // Byte-offset bits are ignored by the decoder.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Readies stay low until the first edge after reset release.
  assign s_axi_awready = init_q & ((w_state_q == W_IDLE) || (w_state_q == W_WAIT_AW));
  assign s_axi_wready  = init_q & ((w_state_q == W_IDLE) || (w_state_q == W_WAIT_W));
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = init_q & (r_state_q == R_IDLE);
  assign s_axi_rvalid  = (r_state_q == R_DATA);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign wr_pulse_o    = wr_pulse_q;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid  & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
    assign ctrl_o[32*g +: 32] = ctrl_q[g];
  end

  // Write FSM next state; picks the address/data pair that commits this edge.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    w_state_d   = w_state_q;
    lat_aw      = 1'b0;
    lat_w       = 1'b0;
    commit      = 1'b0;
    commit_idx  = aw_idx_q;
    commit_data = w_data_q;
    commit_strb = w_strb_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit      = 1'b1;
          commit_idx  = s_axi_awaddr[ADDR_WIDTH-1:2];
          commit_data = s_axi_wdata;
          commit_strb = s_axi_wstrb;
          w_state_d   = W_RESP;
        end else if (aw_hs) begin
          lat_aw    = 1'b1;
          w_state_d = W_WAIT_W;
        end else if (w_hs) begin
          lat_w     = 1'b1;
          w_state_d = W_WAIT_AW;
        end
      end
      W_WAIT_W: begin
        if (w_hs) begin
          commit      = 1'b1;
          commit_data = s_axi_wdata;
          commit_strb = s_axi_wstrb;
          w_state_d   = W_RESP;
        end
      end
      W_WAIT_AW: begin
        if (aw_hs) begin
          commit     = 1'b1;
          commit_idx = s_axi_awaddr[ADDR_WIDTH-1:2];
          w_state_d  = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign commit_idx32 = 32'(commit_idx);
  assign commit_rw    = (commit_idx32 < NUM_RW_U);

  // Write state, latched phases, response and the RW register bank.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      init_q     <= 1'b0;
      w_state_q  <= W_IDLE;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      // NOTE: the register bank is reset because software and PL logic rely on known control values; it is a handful of flops, not a RAM.
      for (int i = 0; i < NUM_RW; i++) ctrl_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so a same-edge read sees the old register contents.
      init_q     <= 1'b1;
      w_state_q  <= w_state_d;
      wr_pulse_q <= '0;
      if (lat_aw) aw_idx_q <= s_axi_awaddr[ADDR_WIDTH-1:2];
      if (lat_w) begin
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (commit) begin
        bresp_q <= commit_rw ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_RW; i++) begin
          if (commit_idx32 == 32'(i)) begin
            wr_pulse_q[i] <= 1'b1;
            for (int b = 0; b < 4; b++) begin
              if (commit_strb[b]) ctrl_q[i][8*b +: 8] <= commit_data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  assign rd_idx32 = 32'(s_axi_araddr[ADDR_WIDTH-1:2]);

  // Read data source: RW register, live status input, or zero when unmapped.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (rd_idx32 == 32'(i)) rd_mux = ctrl_q[i];
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (rd_idx32 == 32'(NUM_RW + j)) rd_mux = status_i[32*j +: 32];
    end
  end

  // Read FSM next state.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (s_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read state and registered read response captured at the AR handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        rdata_q <= rd_mux;
        rresp_q <= (rd_idx32 < NUM_REGS_U) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_regs.sv
// Directed bench for axi_lite_regs: a table of single transactions followed by
// hand-written multi-cycle sequences (split AW/W, held responses, mid-response reset).
module tb_axi_lite_regs;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [11:0]  awaddr = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [11:0]  araddr = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [127:0] ctrl_o;
  logic [3:0]   wr_pulse_o;
  logic [127:0] status_i = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  axi_lite_regs #(.ADDR_WIDTH(12), .NUM_REGS(8), .NUM_RW(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .ctrl_o(ctrl_o), .wr_pulse_o(wr_pulse_o), .status_i(status_i)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // AW and W presented together, bready high.
  task automatic do_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output logic [3:0] pulse);
    int t;
    @(negedge aclk);
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
    t = 0;
    while (!(awready && wready) && t < 20) begin
      @(negedge aclk);
      t++;
    end
    check("wr_ready", {awready, wready}, 2'b11);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid_latency", bvalid, 1'b1);
    resp  = bresp;
    pulse = wr_pulse_o;
    @(negedge aclk);
    check("bvalid_done", bvalid, 1'b0);
    check("pulse_width", wr_pulse_o, 4'h0);
  endtask

  task automatic do_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int t;
    @(negedge aclk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    t = 0;
    while (!arready && t < 20) begin
      @(negedge aclk);
      t++;
    end
    check("rd_ready", arready, 1'b1);
    @(negedge aclk);
    arvalid = 1'b0;
    check("rvalid_latency", rvalid, 1'b1);
    data = rdata;
    resp = rresp;
    @(negedge aclk);
    check("rvalid_done", rvalid, 1'b0);
  endtask

  typedef struct {
    bit           is_wr;
    logic [11:0]  addr;
    logic [31:0]  data;
    logic [3:0]   strb;
    logic [1:0]   exp_resp;
    logic [31:0]  exp_val;   // write: expected wr_pulse_o; read: expected rdata
    logic [127:0] exp_ctrl;
  } vec_t;

  localparam logic [127:0] C1  = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
  localparam logic [127:0] C3  = {32'h0, 32'h0, 32'hDEADBEEF, 32'hAABBCCDD};
  localparam logic [127:0] C4  = {32'h0, 32'h0, 32'hDEADBEEF, 32'hAA22CC44};
  localparam logic [127:0] C14 = {32'h0000ABCD, 32'h0, 32'hDEADBEEF, 32'hAA22CC44};
  localparam logic [127:0] CA  = {32'h0000ABCD, 32'h5, 32'hDEADBEEF, 32'hAA22CC44};
  localparam logic [127:0] CB  = {32'h0000ABCD, 32'h5, 32'h0BADF00D, 32'hAA22CC44};

  vec_t vecs[16];

  initial begin
    logic [1:0]  resp;
    logic [3:0]  pulse;
    logic [31:0] data;

    vecs[0]  = '{1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 2'b00, 32'h2,        C1};
    vecs[1]  = '{1'b0, 12'h004, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, C1};
    vecs[2]  = '{1'b1, 12'h000, 32'hAABBCCDD, 4'hF, 2'b00, 32'h1,        C3};
    vecs[3]  = '{1'b1, 12'h000, 32'h11223344, 4'h5, 2'b00, 32'h1,        C4};
    vecs[4]  = '{1'b0, 12'h000, 32'h0,        4'h0, 2'b00, 32'hAA22CC44, C4};
    vecs[5]  = '{1'b1, 12'h00C, 32'h12345678, 4'h0, 2'b00, 32'h8,        C4};
    vecs[6]  = '{1'b0, 12'h00F, 32'h0,        4'h0, 2'b00, 32'h0,        C4};
    vecs[7]  = '{1'b0, 12'h014, 32'h0,        4'h0, 2'b00, 32'hCAFE0001, C4};
    vecs[8]  = '{1'b1, 12'h014, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0,        C4};
    vecs[9]  = '{1'b0, 12'h014, 32'h0,        4'h0, 2'b00, 32'hCAFE0001, C4};
    vecs[10] = '{1'b0, 12'h3FC, 32'h0,        4'h0, 2'b10, 32'h0,        C4};
    vecs[11] = '{1'b1, 12'h020, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0,        C4};
    vecs[12] = '{1'b0, 12'h01C, 32'h0,        4'h0, 2'b00, 32'h77777777, C4};
    vecs[13] = '{1'b1, 12'h00E, 32'h0000ABCD, 4'h3, 2'b00, 32'h8,        C14};
    vecs[14] = '{1'b0, 12'h00C, 32'h0,        4'h0, 2'b00, 32'h0000ABCD, C14};
    vecs[15] = '{1'b0, 12'h010, 32'h0,        4'h0, 2'b00, 32'h00000044, C14};

    status_i = {32'h77777777, 32'h66666666, 32'hCAFE0001, 32'h00000044};

    // Reset state: every output low, readies included.
    #12;
    check("reset_readies", {awready, wready, arready}, 3'b000);
    check("reset_valids", {bvalid, rvalid}, 2'b00);
    check("reset_ctrl", ctrl_o, 128'h0);
    check("reset_resp_data", {rdata, rresp, bresp, wr_pulse_o}, 40'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("readies_after_reset", {awready, wready, arready}, 3'b111);

    // Table of single transactions.
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, pulse);
        check($sformatf("v%0d_bresp", i), resp, vecs[i].exp_resp);
        check($sformatf("v%0d_pulse", i), pulse, vecs[i].exp_val[3:0]);
      end else begin
        do_read(vecs[i].addr, data, resp);
        check($sformatf("v%0d_rresp", i), resp, vecs[i].exp_resp);
        check($sformatf("v%0d_rdata", i), data, vecs[i].exp_val);
      end
      check($sformatf("v%0d_ctrl", i), ctrl_o, vecs[i].exp_ctrl);
    end

    // W arrives three cycles before AW.
    @(negedge aclk);
    bready = 1'b1;
    wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
    check("split_w_ready", wready, 1'b1);
    @(negedge aclk);
    wvalid = 1'b0;
    check("split_wready_drop", {awready, wready, bvalid}, 3'b100);
    repeat (2) @(negedge aclk);
    check("split_wait", {awready, wready, bvalid}, 3'b100);
    awaddr = 12'h008; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    check("split_bvalid", {bvalid, bresp}, 3'b100);
    check("split_pulse", wr_pulse_o, 4'h4);
    check("split_ctrl", ctrl_o, CA);
    @(negedge aclk);
    check("split_idle", {awready, wready, bvalid}, 3'b110);
    @(negedge aclk);
    check("split_one_bvalid", bvalid, 1'b0);

    // Held responses with concurrent write/read of register 1; read sees the old value.
    bready = 1'b0; rready = 1'b0;
    awaddr = 12'h004; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 12'h004; arvalid = 1'b1;
    @(negedge aclk);
    awaddr = 12'h000; wdata = 32'hFFFFFFFF; araddr = 12'h000;
    check("hold_first_pulse", wr_pulse_o, 4'h2);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold%0d_valids", c), {bvalid, rvalid}, 2'b11);
      check($sformatf("hold%0d_readies", c), {awready, wready, arready}, 3'b000);
      check($sformatf("hold%0d_rdata", c), {rdata, rresp, bresp}, {32'hDEADBEEF, 2'b00, 2'b00});
      check($sformatf("hold%0d_ctrl", c), ctrl_o, CB);
      if (c > 0) check($sformatf("hold%0d_pulse", c), wr_pulse_o, 4'h0);
      @(negedge aclk);
    end

    // Reset mid-response clears outputs without a clock edge.
    #2 aresetn = 1'b0;
    #1;
    check("arst_valids", {bvalid, rvalid, awready, wready, arready}, 5'b0);
    check("arst_ctrl", ctrl_o, 128'h0);
    check("arst_data", {rdata, rresp, bresp, wr_pulse_o}, 40'h0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rerelease", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
    do_read(12'h004, data, resp);
    check("post_reset_rdata", {data, resp}, 34'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
